// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
//   Performs a WIDTH-bit add or subtract by streaming 32-bit chunks, least
//   significant first, through a single 32-bit carry-lookahead adder. The
//   carry between chunks is held in a register. Valid/ready on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands presented          in_ready  block can accept (IDLE)
//   in_a/in_b  WIDTH-bit operands          in_sub    1 = A - B, 0 = A + B + cin
//   in_cin     carry-in for add (ignored for subtract)
//   out_valid  result available            out_ready consumer accepts result
//   out_sum    WIDTH-bit result            out_cout  carry out of MSB
//   out_ovf    signed overflow             busy      high in RUN or DONE
// -----------------------------------------------------------------------------
module wide_add_sequencer #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / 32;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (((WIDTH % 32) != 0) || (WIDTH < 32)) begin : g_bad_width
    $error("wide_add_sequencer: WIDTH must be a multiple of 32 and >= 32");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 32-bit adder built from 4-bit lookahead groups; group carries are chained
  // through group generate/propagate. Returns {cout, sum}.
  function automatic logic [32:0] cla32(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        cin);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic        gg;
    logic        gp;
    g    = a & b;
    p    = a ^ b;
    c    = 33'd0;
    c[0] = cin;
    for (int j = 0; j < 8; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      gg = g[4*j+3] | (p[4*j+3] & g[4*j+2])
         | (p[4*j+3] & p[4*j+2] & g[4*j+1])
         | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
      c[4*j+4] = gg | (gp & c[4*j]);
    end
    return {c[32], p ^ c[31:0]};
  endfunction

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already inverted for subtract
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [31:0]      chunk_a_s;
  logic [31:0]      chunk_b_s;
  logic [32:0]      cla_res_s;
  logic             last_chunk_s;

  // Select the current chunk and run it through the shared adder.
  always_comb begin
    chunk_a_s    = a_q[{k_q, 5'd0} +: 32];
    chunk_b_s    = b_q[{k_q, 5'd0} +: 32];
    cla_res_s    = cla32(chunk_a_s, chunk_b_s, carry_q);
    last_chunk_s = (k_q == KW'(NCHUNK - 1));
  end

  // Control FSM together with operand, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= {KW{1'b0}};
      carry_q     <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub ? 1'b1 : in_cin;
            k_q     <= {KW{1'b0}};
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[{k_q, 5'd0} +: 32] <= cla_res_s[31:0];
          carry_q                  <= cla_res_s[32];
          if (last_chunk_s) begin
            cout_q      <= cla_res_s[32];
            // Same-sign operands producing a different-sign result.
            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (cla_res_s[31] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic rst_n = 1'b0;

  // 128-bit instance signals
  logic         in_valid = 1'b0, in_ready, in_sub = 1'b0, in_cin = 1'b0;
  logic [127:0] in_a = 128'd0, in_b = 128'd0, out_sum;
  logic         out_valid, out_ready = 1'b1, out_cout, out_ovf, busy;

  // 32-bit instance signals
  logic         v32 = 1'b0, r32, sub32 = 1'b0, cin32 = 1'b0;
  logic [31:0]  a32 = 32'd0, b32 = 32'd0, sum32;
  logic         ov32, ordy32 = 1'b1, cout32, ovf32, busy32;

  wide_add_sequencer #(.WIDTH(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy));

  wide_add_sequencer #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32),
    .in_a(a32), .in_b(b32), .in_sub(sub32), .in_cin(cin32),
    .out_valid(ov32), .out_ready(ordy32), .out_sum(sum32),
    .out_cout(cout32), .out_ovf(ovf32), .busy(busy32));

  typedef struct { logic [127:0] sum; logic cout; logic ovf; int acc; } exp_t;
  exp_t sb128[$];
  exp_t sb32[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard monitor for the 128-bit instance.
  logic pv128 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv128 = 1'b0;
    end else begin
      if (out_valid && !pv128) begin
        if (sb128.size() == 0) fail_now("unexpected_valid128");
        else check("latency128", 128'(cyc - sb128[0].acc), 128'd4);
      end
      if (out_valid && out_ready) begin
        if (sb128.size() == 0) fail_now("unexpected_result128");
        else begin
          e = sb128.pop_front();
          check("sum128", out_sum, e.sum);
          check("cout128", 128'(out_cout), 128'(e.cout));
          check("ovf128", 128'(out_ovf), 128'(e.ovf));
        end
      end
      pv128 = out_valid;
    end
  end

  // Scoreboard monitor for the 32-bit instance.
  logic pv32 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pv32 = 1'b0;
    end else begin
      if (ov32 && !pv32) begin
        if (sb32.size() == 0) fail_now("unexpected_valid32");
        else check("latency32", 128'(cyc - sb32[0].acc), 128'd1);
      end
      if (ov32 && ordy32) begin
        if (sb32.size() == 0) fail_now("unexpected_result32");
        else begin
          e = sb32.pop_front();
          check("sum32", 128'(sum32), e.sum);
          check("cout32", 128'(cout32), 128'(e.cout));
          check("ovf32", 128'(ovf32), 128'(e.ovf));
        end
      end
      pv32 = ov32;
    end
  end

  task automatic issue128(input logic [127:0] a, input logic [127:0] b,
                          input logic sub, input logic cin,
                          input logic [127:0] esum, input logic ecout, input logic eovf);
    exp_t e;
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) fail_now("in_ready128_timeout");
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_cin = cin;
    e.sum = esum; e.cout = ecout; e.ovf = eovf; e.acc = cyc + 1;
    sb128.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  int last_acc32 = 0;
  task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin);
    exp_t e;
    logic [31:0] bb;
    logic [32:0] full;
    int n = 0;
    @(posedge clk); #1;
    while (!r32 && n < 100) begin @(posedge clk); #1; n++; end
    if (!r32) fail_now("in_ready32_timeout");
    v32 = 1'b1; a32 = a; b32 = b; sub32 = sub; cin32 = cin;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + (sub ? 33'd1 : {32'd0, cin});
    e.sum = 128'(full[31:0]);
    e.cout = full[32];
    e.ovf = (a[31] == bb[31]) && (full[31] != a[31]);
    e.acc = cyc + 1;
    last_acc32 = e.acc;
    sb32.push_back(e);
    @(posedge clk); #1;
    v32 = 1'b0;
  endtask

  task automatic drain128();
    int n = 0;
    while (sb128.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    check("drain128", 128'(sb128.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ones;
    logic [127:0] msb;
    int prev;
    ones = {128{1'b1}};
    msb  = {1'b1, 127'd0};

    // Reset state
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_sum", out_sum, 128'd0);
    check("rst_cout_ovf", 128'({out_cout, out_ovf}), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Carry ripple across three chunk boundaries
    issue128(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
             128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);
    drain128();
    issue128(ones, 128'd0, 1'b0, 1'b1, 128'd0, 1'b1, 1'b0);
    drain128();
    issue128(~msb, 128'd1, 1'b0, 1'b0, msb, 1'b0, 1'b1);
    drain128();
    // Subtract; in_cin=1 must be ignored
    issue128(128'd0, 128'd1, 1'b1, 1'b1, ones, 1'b0, 1'b0);
    drain128();
    issue128(msb, 128'd1, 1'b1, 1'b1, ~msb, 1'b1, 1'b1);
    drain128();

    // Backpressure in DONE with ignored input traffic
    out_ready = 1'b0;
    issue128(128'd100, 128'd23, 1'b0, 1'b0, 128'd123, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_a = 128'(i + 1000);
      in_b = 128'(i + 77);
      check("bp_sum", out_sum, 128'd123);
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 128'(out_valid), 128'd0);
    check("bp_release_ready", 128'(in_ready), 128'd1);
    check("bp_release_busy", 128'(busy), 128'd0);
    check("bp_popped", 128'(sb128.size()), 128'd0);

    // Reset in the middle of RUN (k=2)
    issue128({4{32'h1111_1111}}, {4{32'h2222_2222}}, 1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(out_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_ready", 128'(in_ready), 128'd1);
    check("midrst_sum", out_sum, 128'd0);
    sb128.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue128(128'd5, 128'd7, 1'b0, 1'b0, 128'd12, 1'b0, 1'b0);
    drain128();

    // 32-bit instance: back-to-back random operations
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      issue32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i > 0) check("spacing32", 128'(last_acc32 - prev), 128'd3);
      prev = last_acc32;
    end
    begin
      int n = 0;
      while (sb32.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
      check("drain32", 128'(sb32.size()), 128'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-cycle controller that performs WIDTH-bit add/subtract by streaming 32-bit chunks, least-significant first, through one internal 32-bit carry-lookahead adder (CLA32), chaining the carry between chunks in a register. Sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. It lets wide datapaths share one 32-bit CLA instead of instantiating a WIDTH-bit adder.

Parameters:
WIDTH, 128, operand/result width; must be a multiple of 32 and >= 32 (elaboration error otherwise)
NCHUNK, WIDTH/32, derived localparam: number of 32-bit passes per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept an operation
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_sub  input  1  1 = A - B, 0 = A + B + in_cin
in_cin  input  1  carry-in for add; ignored when in_sub=1
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  result
out_cout  output  1  carry out of MSB (for sub: 1 = no borrow)
out_ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low. While rst_n=0: state=IDLE, chunk index=0, carry reg=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, in_ready=1 (in_ready is combinational from state).
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch A; latch B' = in_sub ? ~in_b : in_b; carry reg <= in_sub ? 1 : in_cin; chunk index <= 0; go RUN.
- RUN: in_ready=0. Each cycle the CLA32 adds chunk k of A and B' with carry reg as Cin; out_sum[32k+31:32k] <= sum; carry reg <= Cout; k <= k+1. After chunk NCHUNK-1: out_cout <= Cout; out_ovf <= (A[WIDTH-1] == B'[WIDTH-1]) && (new sum MSB != A[WIDTH-1]); go DONE.
- Latency: out_valid rises exactly NCHUNK clock edges after the accepting edge (WIDTH=128 -> 4, WIDTH=32 -> 1).
- DONE: out_valid=1; out_sum/out_cout/out_ovf held stable until out_valid&&out_ready, then go IDLE with out_valid=0. Result registers keep their last value in IDLE; they are only updated in RUN.
- No same-cycle turnaround: the next operation can be accepted at the earliest in the cycle after the result handshake (in_ready=0 in DONE). Throughput is 1 operation per NCHUNK+2 cycles with out_ready held high.
- in_valid, in_a, in_b, in_sub, in_cin are ignored outside IDLE; operands are sampled only at the accept edge.
- Chunk index width is clog2(NCHUNK) with a minimum of 1 bit. The index never wraps inside an operation; the terminal compare is k == NCHUNK-1.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned with no output handshake; all state returns to reset values immediately.
- Carry chain: the carry into chunk 0 comes only from in_sub/in_cin; there is no carry leakage between operations.

Test Plan:
1. WIDTH=128 add: A=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1, cin=0 -> sum=0x0000_0001_0000_0000_0000_0000_0000_0000, cout=0, ovf=0; out_valid exactly 4 edges after accept.
2. Add all-ones + 0 with cin=1 -> sum=0, cout=1, ovf=0. Add A=0x7FFF..F + B=1 -> sum=0x8000..0, cout=0, ovf=1.
3. Sub: A=0, B=1 -> sum=0xFFFF..F, cout=0, ovf=0. Sub: A=0x8000..0, B=1 -> sum=0x7FFF..F, cout=1, ovf=1. in_cin=1 has no effect on either result.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands -> out_* stable, in_ready=0, no new operation starts. Release out_ready -> handshake, then in_ready=1 next cycle.
5. Pulse rst_n low while k=2 of a 128-bit operation -> out_valid=0 and busy=0 immediately. After release, a new operation 5+7 -> sum=12 with 4-cycle latency.
6. WIDTH=32 instance: back-to-back random ops with out_ready=1 -> each result matches the reference model, latency 1, accepts spaced 3 cycles apart.
